// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: default widths, ALU function codes
// and the arbiter FSM state encoding.
package alu_pkg;

  localparam int ALU_DATA_WIDTH = 32;
  localparam int ALU_FUNC_WIDTH = 4;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4
  } alu_func_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick; on a tie the port that did not win
// last time is chosen.
module rr_arb2 (
  input  logic Req0,
  input  logic Req1,
  input  logic LastGrant,
  output logic GrantValid,
  output logic GrantIdx
);

  assign GrantValid = Req0 | Req1;
  assign GrantIdx   = (Req0 & Req1) ? ~LastGrant : Req1;

endmodule

// File: rtl/alu_arbiter.sv
// Shares one negedge-evaluating ALU between two requesters. Handshake: a port
// holds Req and its inputs stable until its one-cycle Done; inputs are latched
// on the grant edge and the result is returned three cycles per operation.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = ALU_DATA_WIDTH,
  parameter int FUNC_WIDTH = ALU_FUNC_WIDTH
) (
  input  logic                  ClockInput,
  input  logic                  ResetInputN,
  input  logic                  Req0,
  input  logic                  Req1,
  input  logic [DATA_WIDTH-1:0] PriOperand0,
  input  logic [DATA_WIDTH-1:0] PriOperand1,
  input  logic [DATA_WIDTH-1:0] SecOperand0,
  input  logic [DATA_WIDTH-1:0] SecOperand1,
  input  logic [DATA_WIDTH-1:0] OffsetOperand0,
  input  logic [DATA_WIDTH-1:0] OffsetOperand1,
  input  logic                  AddrCalc0,
  input  logic                  AddrCalc1,
  input  logic [FUNC_WIDTH-1:0] Function0,
  input  logic [FUNC_WIDTH-1:0] Function1,
  output logic                  Done0,
  output logic                  Done1,
  output logic [DATA_WIDTH-1:0] RespResult,
  output logic                  RespZero,
  output logic                  Busy,
  output logic [DATA_WIDTH-1:0] AluPriOperand,
  output logic [DATA_WIDTH-1:0] AluSecOperand,
  output logic [DATA_WIDTH-1:0] AluOffsetOperand,
  output logic                  AluAddressCalculate,
  output logic [FUNC_WIDTH-1:0] AluFunction,
  input  logic [DATA_WIDTH-1:0] AluResult,
  input  logic                  AluZeroFlag,
  output logic [1:0]            DbgState
);

  arb_state_e              r_state;
  arb_state_e              w_next_state;
  logic                    r_owner;
  logic                    r_last_grant;
  logic [DATA_WIDTH-1:0]   r_alu_pri;
  logic [DATA_WIDTH-1:0]   r_alu_sec;
  logic [DATA_WIDTH-1:0]   r_alu_off;
  logic                    r_alu_ac;
  logic [FUNC_WIDTH-1:0]   r_alu_func;
  logic [DATA_WIDTH-1:0]   r_resp_result;
  logic                    r_resp_zero;

  logic                    w_grant_valid;
  logic                    w_grant_idx;

  rr_arb2 u_rr_arb2 (
    .Req0       (Req0),
    .Req1       (Req1),
    .LastGrant  (r_last_grant),
    .GrantValid (w_grant_valid),
    .GrantIdx   (w_grant_idx)
  );

  always_comb begin
    w_next_state = IDLE;
    case (r_state)
      IDLE:    w_next_state = w_grant_valid ? ISSUE : IDLE;
      ISSUE:   w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge ClockInput or negedge ResetInputN) begin
    if (!ResetInputN) begin
      r_state       <= IDLE;
      r_owner       <= 1'b0;
      r_last_grant  <= 1'b1;
      r_alu_pri     <= '0;
      r_alu_sec     <= '0;
      r_alu_off     <= '0;
      r_alu_ac      <= 1'b0;
      r_alu_func    <= '0;
      r_resp_result <= '0;
      r_resp_zero   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (r_state == IDLE && w_grant_valid) begin
        r_owner      <= w_grant_idx;
        r_last_grant <= w_grant_idx;
        r_alu_pri    <= w_grant_idx ? PriOperand1    : PriOperand0;
        r_alu_sec    <= w_grant_idx ? SecOperand1    : SecOperand0;
        r_alu_off    <= w_grant_idx ? OffsetOperand1 : OffsetOperand0;
        r_alu_ac     <= w_grant_idx ? AddrCalc1      : AddrCalc0;
        r_alu_func   <= w_grant_idx ? Function1      : Function0;
      end
      // The ALU settled on the negedge inside ISSUE, so its outputs are stable here.
      if (r_state == ISSUE) begin
        r_resp_result <= AluResult;
        r_resp_zero   <= AluZeroFlag;
      end
    end
  end

  assign Done0               = (r_state == DONE) && !r_owner;
  assign Done1               = (r_state == DONE) &&  r_owner;
  assign Busy                = (r_state != IDLE);
  assign RespResult          = r_resp_result;
  assign RespZero            = r_resp_zero;
  assign AluPriOperand       = r_alu_pri;
  assign AluSecOperand       = r_alu_sec;
  assign AluOffsetOperand    = r_alu_off;
  assign AluAddressCalculate = r_alu_ac;
  assign AluFunction         = r_alu_func;
  assign DbgState            = r_state;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a negedge ALU stub and an ordered
// scoreboard of expected {port, result} completions.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int DW = 32;
  localparam int FW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic [DW-1:0] pri0 = '0, pri1 = '0, sec0 = '0, sec1 = '0, off0 = '0, off1 = '0;
  logic          ac0 = 1'b0, ac1 = 1'b0;
  logic [FW-1:0] fn0 = '0, fn1 = '0;
  logic          done0, done1, resp_zero, busy, alu_ac;
  logic [DW-1:0] resp_result, alu_pri, alu_sec, alu_off;
  logic [FW-1:0] alu_func;
  logic [DW-1:0] alu_result = '0;
  logic          alu_zero = 1'b0;
  logic [1:0]    dbg_state;

  int            n_cmp = 0;
  int            n_err = 0;
  logic [DW:0]   exp_q[$];
  logic [DW:0]   exp_e;
  logic [DW-1:0] alu_b;

  alu_arbiter dut (
    .ClockInput(clk), .ResetInputN(rst_n),
    .Req0(req0), .Req1(req1),
    .PriOperand0(pri0), .PriOperand1(pri1),
    .SecOperand0(sec0), .SecOperand1(sec1),
    .OffsetOperand0(off0), .OffsetOperand1(off1),
    .AddrCalc0(ac0), .AddrCalc1(ac1),
    .Function0(fn0), .Function1(fn1),
    .Done0(done0), .Done1(done1),
    .RespResult(resp_result), .RespZero(resp_zero), .Busy(busy),
    .AluPriOperand(alu_pri), .AluSecOperand(alu_sec), .AluOffsetOperand(alu_off),
    .AluAddressCalculate(alu_ac), .AluFunction(alu_func),
    .AluResult(alu_result), .AluZeroFlag(alu_zero),
    .DbgState(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ALU stub: evaluates on the falling edge
  always @(negedge clk) begin
    alu_b = alu_ac ? alu_off : alu_sec;
    case (alu_func)
      4'd1:    alu_result = alu_pri - alu_b;
      4'd2:    alu_result = alu_pri & alu_b;
      4'd3:    alu_result = alu_pri | alu_b;
      4'd4:    alu_result = alu_pri ^ alu_b;
      default: alu_result = alu_pri + alu_b;
    endcase
    alu_zero = (alu_result == '0);
  end

  task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_done0"}, done0, 0);
    check_eq({tag, "_done1"}, done1, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_state"}, dbg_state, 0);
    check_eq({tag, "_resp"}, resp_result, 0);
    check_eq({tag, "_zero"}, resp_zero, 0);
    check_eq({tag, "_apri"}, alu_pri, 0);
    check_eq({tag, "_asec"}, alu_sec, 0);
    check_eq({tag, "_aoff"}, alu_off, 0);
    check_eq({tag, "_aac"}, alu_ac, 0);
    check_eq({tag, "_afn"}, alu_func, 0);
  endtask

  // driver tasks
  task automatic set_port(input int port, input logic [DW-1:0] pri, input logic [DW-1:0] sec,
                          input logic [DW-1:0] off, input logic ac, input logic [FW-1:0] fn);
    if (port == 0) begin
      pri0 = pri; sec0 = sec; off0 = off; ac0 = ac; fn0 = fn;
    end else begin
      pri1 = pri; sec1 = sec; off1 = off; ac1 = ac; fn1 = fn;
    end
  endtask

  // Single request from one port; called #1 after a posedge with the DUT idle.
  task automatic run_single(input string tag, input int port, input logic [DW-1:0] pri,
                            input logic [DW-1:0] sec, input logic [DW-1:0] off, input logic ac,
                            input logic [FW-1:0] fn, input logic [DW-1:0] exp_res, input logic exp_z);
    int  cyc;
    bit  got;
    set_port(port, pri, sec, off, ac, fn);
    if (port == 0) req0 = 1'b1; else req1 = 1'b1;
    cyc = 0;
    got = 0;
    while (!got && cyc < 8) begin
      @(posedge clk); #1;
      cyc++;
      check_eq({tag, "_busy"}, busy, 1);
      check_eq({tag, "_other_done"}, (port == 0) ? done1 : done0, 0);
      if (cyc == 1) begin
        check_eq({tag, "_alu_pri"}, alu_pri, pri);
        check_eq({tag, "_alu_ac"}, alu_ac, ac);
        check_eq({tag, "_alu_fn"}, alu_func, fn);
      end
      got = (port == 0) ? done0 : done1;
    end
    check_eq({tag, "_latency"}, cyc, 2);
    check_eq({tag, "_result"}, resp_result, exp_res);
    check_eq({tag, "_zero"}, resp_zero, exp_z);
    if (port == 0) req0 = 1'b0; else req1 = 1'b0;
    @(posedge clk); #1;
    check_eq({tag, "_done_drop"}, done0 | done1, 0);
    check_eq({tag, "_idle"}, busy, 0);
    check_eq({tag, "_resp_hold"}, resp_result, exp_res);
  endtask

  // Consume completions against exp_q within a cycle budget.
  task automatic drain(input string tag, input int budget);
    for (int c = 0; c < budget && exp_q.size() > 0; c++) begin
      @(posedge clk); #1;
      if (done0 || done1) begin
        exp_e = exp_q.pop_front();
        check_eq({tag, "_one_hot"}, done0 & done1, 0);
        check_eq({tag, "_port"}, done1, exp_e[DW]);
        check_eq({tag, "_result"}, resp_result, exp_e[DW-1:0]);
      end
    end
    check_eq({tag, "_drained"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #12;
    check_zero_outputs("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    run_single("sub", 0, 32'd7, 32'd5, 32'd0, 1'b0, 4'd1, 32'd2, 1'b0);
    check_eq("idle_hold_pri", alu_pri, 32'd7);
    check_eq("idle_hold_fn", alu_func, 4'd1);
    run_single("addr", 1, 32'h1000, 32'hFFFF, 32'h20, 1'b1, 4'd0, 32'h1020, 1'b0);
    run_single("xor0", 0, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'd0, 1'b0, 4'd4, 32'd0, 1'b1);
    run_single("and1", 1, 32'hF0F0, 32'h0FF0, 32'd0, 1'b0, 4'd2, 32'h00F0, 1'b0);
    run_single("fn9", 0, 32'd3, 32'd4, 32'd0, 1'b0, 4'd9, 32'd7, 1'b0);

    // Tie from reset release: both held high, expect 0,1,0,1.
    rst_n = 1'b0;
    set_port(0, 32'd3, 32'd4, 32'd0, 1'b0, 4'd0);
    set_port(1, 32'hF0, 32'h0F, 32'd0, 1'b0, 4'd3);
    req0 = 1'b1;
    req1 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back({1'b0, 32'd7});
      exp_q.push_back({1'b1, 32'hFF});
    end
    @(negedge clk) rst_n = 1'b1;
    drain("fair", 30);
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check_eq("quiet_busy", busy, 0);

    // Port 0 granted alone (pointer now 0), then reset during ISSUE.
    set_port(0, 32'd9, 32'd4, 32'd0, 1'b0, 4'd1);
    req0 = 1'b1;
    @(posedge clk); #1;
    check_eq("mid_issue_state", dbg_state, 1);
    req1 = 1'b1;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("mid_rst");
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check_eq("mid_rst_nodone", done0 | done1, 0);
      check_eq("mid_rst_busy", busy, 0);
    end
    exp_q.push_back({1'b0, 32'd5});
    exp_q.push_back({1'b1, 32'hFF});
    @(negedge clk) rst_n = 1'b1;
    drain("post_rst", 12);
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (4) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single negedge-evaluating ALU between two requesters: port 0 (execute unit) and port 1 (address/branch unit).
- Arbitrates round-robin and registers the winner's operands, function and address-mode onto the ALU inputs.
- Waits for the ALU's negedge evaluation, then captures Result and ZeroFlag and returns them to the winner with a one-cycle Done pulse.
- Sits between the control path and the ALU in the MIPS datapath.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- FUNC_WIDTH, 4, ALU function code width.

Ports:
- ClockInput  in  1  system clock; all state on posedge.
- ResetInputN  in  1  asynchronous, active-low reset.
- Req0 / Req1  in  1  request, held high until matching Done.
- PriOperand0 / PriOperand1  in  DATA_WIDTH  primary operand.
- SecOperand0 / SecOperand1  in  DATA_WIDTH  secondary operand.
- OffsetOperand0 / OffsetOperand1  in  DATA_WIDTH  offset operand.
- AddrCalc0 / AddrCalc1  in  1  select offset instead of secondary.
- Function0 / Function1  in  FUNC_WIDTH  ALU function code.
- Done0 / Done1  out  1  one-cycle completion pulse.
- RespResult  out  DATA_WIDTH  captured ALU result.
- RespZero  out  1  captured ALU zero flag.
- Busy  out  1  high in ISSUE and DONE.
- AluPriOperand / AluSecOperand / AluOffsetOperand  out  DATA_WIDTH  registered ALU operand drives.
- AluAddressCalculate  out  1  registered ALU address-mode drive.
- AluFunction  out  FUNC_WIDTH  registered ALU function drive.
- AluResult  in  DATA_WIDTH  ALU Result.
- AluZeroFlag  in  1  ALU ZeroFlag.

Behaviour:
- Clock and reset: one clock, ClockInput. Reset is asynchronous and active-low on ResetInputN.
- Reset values:
  - All outputs 0; state IDLE.
  - Round-robin pointer LastGrant = 1, so port 0 wins the first tie.
- FSM states: IDLE, ISSUE, DONE.
- IDLE:
  - Neither Req high: stay in IDLE.
  - Exactly one Req high: grant that port.
  - Both Req high: grant the port != LastGrant.
  - On the grant edge, in the same posedge: register the winner's operands, AddrCalc and Function onto the Alu* outputs; record Owner; set LastGrant = Owner; go to ISSUE.
- ISSUE:
  - Alu* outputs held stable for the whole cycle.
  - ALU evaluates at this cycle's negedge; ZeroFlag settles before the next posedge.
  - Next posedge: RespResult <= AluResult, RespZero <= AluZeroFlag, DoneOwner <= 1; go to DONE.
- DONE:
  - Done pulse high for exactly this cycle; RespResult and RespZero valid.
  - Next posedge: DoneOwner <= 0; go to IDLE.
  - RespResult and RespZero hold until the next capture.
- Latency: Req high at edge k means Done high during cycle k+2; RespResult is valid in that same cycle.
- Throughput: one operation per 3 cycles.
- Handshake rules:
  - Requester holds its inputs stable from raising Req until it sees Done.
  - Requester drops Req at the edge after Done; Req still high in IDLE counts as a new request.
  - Req/inputs of the owner are ignored after the grant edge; operands are latched.
  - Req of the losing port is not latched; it is re-evaluated in the next IDLE.
- Fairness: two ports requesting continuously alternate 0,1,0,1.
- Function passthrough: Function codes are passed unmodified. Codes 5..15 are not trapped; the ALU treats them as addition.
- Busy = (state != IDLE).
- Alu* outputs keep their last values in IDLE; they are not zeroed.
- Reset mid-operation (ISSUE or DONE):
  - Immediate return to IDLE; no Done is issued and the transaction is lost.
  - Outputs and LastGrant return to reset values.
- Illegal state encodings: recover to IDLE on the next posedge.

Decomposition:
- Shared package alu_pkg:
  - DATA_WIDTH and FUNC_WIDTH defaults.
  - Function codes: ALU_ADD=0, ALU_SUB=1, ALU_AND=2, ALU_OR=3, ALU_XOR=4.
  - FSM state encoding: IDLE=0, ISSUE=1, DONE=2.
- One natural sub-module, rr_arb2: combinational two-way round-robin pick.
  - Inputs: Req0, Req1, LastGrant.
  - Outputs: GrantValid, GrantIdx.
  - The pointer register stays in alu_arbiter.

Test Plan:
- Single request: Req0=1, Pri=7, Sec=5, Func=SUB, AddrCalc=0 at edge k → Done0 during cycle k+2, RespResult=2, RespZero=0, Busy high cycles k+1..k+2, Done1 never asserts.
- Address mode: Req1=1, Pri=0x1000, Sec=0xFFFF, Offset=0x20, AddrCalc=1, Func=ADD → RespResult=0x1020 on Done1.
- Zero flag: Req0 with Pri=0xA5A5A5A5, Sec=0xA5A5A5A5, Func=XOR → RespResult=0, RespZero=1.
- Tie and fairness: Req0 and Req1 both held high from reset release for 4 transactions → Done order 0,1,0,1.
- Each result matches its port's operands: port0 ADD 3+4=7, port1 OR 0xF0|0x0F=0xFF.
- Reset mid-op: assert ResetInputN=0 during ISSUE → no Done pulse, all outputs 0, state IDLE. After release with Req0 and Req1 both high, port 0 is granted first.
